// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: one outstanding instruction read, forwards words to decode,
// stalls on control flow until the store stage returns the next PC. Optional FETCH_PERF_COUNTERS_EN.
module fetch_pc_sequencer #(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          INSTR_W     = 32,
    parameter int unsigned          INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s2f_valid,
    input  logic [ADDR_W-1:0]   s2f_pc,
    output logic                s2f_ready,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [INSTR_W-1:0]  mem_rsp_data,
    output logic                f2d_valid,
    input  logic                f2d_ready,
    output logic [INSTR_W-1:0]  f2d_instr,
    output logic [ADDR_W-1:0]   f2d_pc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_redirects,
    output logic [15:0]         perf_dropped
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_RSP,
        S_EMIT,
        S_WAIT_REDIR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic                   redir_vld_q, redir_vld_d;
    logic [ADDR_W-1:0]      redir_pc_q, redir_pc_d;
    logic                   drop_q, drop_d;
    logic [INSTR_W-1:0]     f2d_instr_d;
    logic [ADDR_W-1:0]      f2d_pc_d;

    logic                   req_fire_c;
    logic                   f2d_fire_c;
    logic                   s2f_fire_c;
    logic                   redirect_c;
    logic [ADDR_W-1:0]      redirect_pc_c;
    logic                   is_ctrl_c;

    assign req_fire_c    = mem_req_valid & mem_req_ready;
    assign f2d_fire_c    = f2d_valid & f2d_ready;
    assign s2f_fire_c    = s2f_valid & s2f_ready;
    assign redirect_c    = redir_vld_q | s2f_fire_c;
    assign redirect_pc_c = redir_vld_q ? redir_pc_q : s2f_pc;
    assign is_ctrl_c     = (f2d_instr[6:4] == 3'b110);
    assign mem_req_addr  = pc_q;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            redir_vld_q   <= 1'b0;
            redir_pc_q    <= '0;
            drop_q        <= 1'b0;
            f2d_instr     <= '0;
            f2d_pc        <= '0;
            mem_req_valid <= 1'b0;
            f2d_valid     <= 1'b0;
            s2f_ready     <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_vld_q   <= redir_vld_d;
            redir_pc_q    <= redir_pc_d;
            drop_q        <= drop_d;
            f2d_instr     <= f2d_instr_d;
            f2d_pc        <= f2d_pc_d;
            mem_req_valid <= (state_d == S_REQ) && !drop_d;
            f2d_valid     <= (state_d == S_EMIT);
            s2f_ready     <= !redir_vld_d || (state_d == S_WAIT_REDIR);
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_vld_d = redir_vld_q;
        redir_pc_d  = redir_pc_q;
        drop_d      = drop_q;
        f2d_instr_d = f2d_instr;
        f2d_pc_d    = f2d_pc;

        // A packet taken outside WAIT_REDIR is parked until a state can consume it
        if (s2f_fire_c && (state_q != S_WAIT_REDIR)) begin
            redir_vld_d = 1'b1;
            redir_pc_d  = s2f_pc;
        end

        case (state_q)
            S_REQ: begin
                if (drop_q) begin
                    if (mem_rsp_valid) begin
                        drop_d = 1'b0;
                    end
                end else if (req_fire_c) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (redirect_c) begin
                    pc_d        = redirect_pc_c;
                    redir_vld_d = 1'b0;
                    drop_d      = !mem_rsp_valid;
                    state_d     = S_REQ;
                end else if (mem_rsp_valid) begin
                    f2d_instr_d = mem_rsp_data;
                    f2d_pc_d    = pc_q;
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (f2d_fire_c) begin
                    if (is_ctrl_c && !redirect_c) begin
                        state_d = S_WAIT_REDIR;
                    end else if (redirect_c) begin
                        pc_d        = redirect_pc_c;
                        redir_vld_d = 1'b0;
                        state_d     = S_REQ;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT_REDIR: begin
                if (s2f_fire_c) begin
                    pc_d    = s2f_pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic perf_drop_c;

    assign perf_drop_c = mem_rsp_valid &&
                         (((state_q == S_REQ) && drop_q) ||
                          ((state_q == S_RSP) && redirect_c));

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_dropped   <= '0;
        end else begin
            if (f2d_fire_c && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (s2f_fire_c && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (perf_drop_c && (perf_dropped != '1)) begin
                perf_dropped <= perf_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboard bench for fetch_pc_sequencer: expected requests and decode deliveries are queued
// as stimulus is set up and popped when the DUT handshakes them.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s2f_valid = 1'b0;
    logic [31:0] s2f_pc = '0;
    logic        s2f_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        f2d_valid;
    logic        f2d_ready = 1'b1;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    logic [15:0] perf_dropped;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_f2d_q[$];
    logic [31:0] br_q[$];

    logic        rsp_en = 1'b1;
    logic        inject_req = 1'b0;
    logic        req_fire_n = 1'b0;
    logic [31:0] req_addr_n = '0;

    fetch_pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .s2f_valid     (s2f_valid),
        .s2f_pc        (s2f_pc),
        .s2f_ready     (s2f_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .f2d_valid     (f2d_valid),
        .f2d_ready     (f2d_ready),
        .f2d_instr     (f2d_instr),
        .f2d_pc        (f2d_pc)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_redirects(perf_redirects),
        .perf_dropped  (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction memory image: listed addresses hold a branch, everything else a plain op
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        foreach (br_q[i]) begin
            if (br_q[i] == a) return 32'h0000_0063;
        end
        return {a[23:0], 8'h13};
    endfunction

    task automatic exp_fetch(input logic [31:0] a, input bit deliver);
        exp_req_q.push_back(a);
        if (deliver) exp_f2d_q.push_back({a, mem_word(a)});
    endtask

    // Monitor: pop scoreboards on handshakes, sampled mid-cycle
    always @(negedge clk) begin
        req_fire_n = mem_req_valid && mem_req_ready && !reset;
        req_addr_n = mem_req_addr;
        if (!reset && mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) check_eq("req_extra", 64'(mem_req_addr), 64'hFFFF_FFFF_0000_0000);
            else check_eq("req_addr", 64'(mem_req_addr), 64'(exp_req_q.pop_front()));
        end
        if (!reset && f2d_valid && f2d_ready) begin
            if (exp_f2d_q.size() == 0) check_eq("f2d_extra", {f2d_pc, f2d_instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check_eq("f2d_pc_instr", {f2d_pc, f2d_instr}, exp_f2d_q.pop_front());
        end
    end

    // Memory model: fixed one-cycle response, plus an injectable stray response
    always @(posedge clk) begin
        #1;
        mem_rsp_valid = (req_fire_n && rsp_en) || inject_req;
        mem_rsp_data  = inject_req ? 32'h0000_0013 : mem_word(req_addr_n);
    end

    task automatic wait_drain();
        int n = 0;
        while ((exp_req_q.size() != 0 || exp_f2d_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(exp_req_q.size() + exp_f2d_q.size()), 64'd0);
    endtask

    task automatic send_s2f(input logic [31:0] pc);
        int n = 0;
        @(posedge clk);
        #1;
        s2f_valid = 1'b1;
        s2f_pc    = pc;
        @(negedge clk);
        while (!s2f_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("s2f_accept", 64'(s2f_ready), 64'd1);
        @(posedge clk);
        #1;
        s2f_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        br_q.push_back(32'h8);
        br_q.push_back(32'h104);
        br_q.push_back(32'h200);
        br_q.push_back(32'h400);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst_f2d_valid", 64'(f2d_valid), 64'd0);
        check_eq("rst_f2d_payload", {f2d_pc, f2d_instr}, 64'd0);
        check_eq("rst_req_addr", 64'(mem_req_addr), 64'd0);

        // Sequential fetch 0,4,8; branch at 8 stalls
        exp_fetch(32'h0, 1'b1);
        exp_fetch(32'h4, 1'b1);
        exp_fetch(32'h8, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        check_eq("wait_no_req", 64'(mem_req_valid), 64'd0);
        check_eq("wait_s2f_ready", 64'(s2f_ready), 64'd1);
        check_eq("wait_no_f2d", 64'(f2d_valid), 64'd0);

        // Resolved branch target
        exp_fetch(32'h100, 1'b1);
        exp_fetch(32'h104, 1'b1);
        send_s2f(32'h100);
        wait_drain();

        // Redirect coincident with the response for pc 4
        exp_fetch(32'h0, 1'b1);
        exp_fetch(32'h4, 1'b0);
        exp_fetch(32'h200, 1'b1);
        send_s2f(32'h0);
        begin
            int n = 0;
            while (!(mem_req_valid && mem_req_ready && mem_req_addr == 32'h4) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_eq("see_req4", 64'(mem_req_addr), 64'h4);
        end
        send_s2f(32'h200);
        wait_drain();
        repeat (3) @(negedge clk);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("perf_dropped", 64'(perf_dropped), 64'd1);
        check_eq("perf_fetched", 64'(perf_fetched), 64'd7);
        check_eq("perf_redirects", 64'(perf_redirects), 64'd3);
`endif

        // Redirect during a stalled EMIT: payload holds, redirect applies after delivery
        f2d_ready = 1'b0;
        exp_fetch(32'h300, 1'b1);
        exp_fetch(32'h400, 1'b1);
        send_s2f(32'h300);
        begin
            int n = 0;
            while (!f2d_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_eq("emit_seen", 64'(f2d_valid), 64'd1);
        end
        send_s2f(32'h400);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 64'(f2d_valid), 64'd1);
            check_eq("stall_payload", {f2d_pc, f2d_instr}, {32'h300, mem_word(32'h300)});
            check_eq("stall_s2f_ready", 64'(s2f_ready), 64'd0);
            check_eq("stall_no_req", 64'(mem_req_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 f2d_ready = 1'b1;
        wait_drain();

        // PC wrap at the top of the address space
        exp_fetch(32'hFFFF_FFFC, 1'b1);
        exp_fetch(32'h0, 1'b1);
        exp_fetch(32'h4, 1'b1);
        exp_fetch(32'h8, 1'b1);
        send_s2f(32'hFFFF_FFFC);
        wait_drain();

        // Reset while a read is outstanding; the late response must be ignored
        rsp_en = 1'b0;
        exp_fetch(32'h500, 1'b0);
        send_s2f(32'h500);
        wait_drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_req_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        inject_req = 1'b1;
        @(negedge clk);
        inject_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("post_rst_no_f2d", 64'(f2d_valid), 64'd0);
            @(negedge clk);
        end
        check_eq("post_rst_req_valid", 64'(mem_req_valid), 64'd1);
        check_eq("post_rst_req_addr", 64'(mem_req_addr), 64'h0);
        rsp_en = 1'b1;
        exp_fetch(32'h0, 1'b1);
        exp_fetch(32'h4, 1'b1);
        exp_fetch(32'h8, 1'b1);
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        wait_drain();
        repeat (3) @(negedge clk);
`ifdef FETCH_PERF_COUNTERS_EN
        check_eq("perf_fetched_rst", 64'(perf_fetched), 64'd3);
        check_eq("perf_redirects_rst", 64'(perf_redirects), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
